mips_lsu_bus: RTL and testbench
===============================

// Module: mips_lsu_bus
// PURPOSE
//  Parametrised load/store unit between the multicycle MIPS core and the Avalon-MM master bus.
//  Accepts one byte/half/word request at a time and generates the byteenable lanes and replicated writedata.
//  Runs the waitrequest handshake, then returns load data aligned and sign/zero-extended to 32 bits.
//  Misaligned halfword/word accesses are rejected with an error instead of reaching the bus.
// PARAMETERS
//  ADDR_W          32  byte-address width, core and bus side
//  DATA_W          32  bus data width; legal values 32 or 64; BE_W = DATA_W/8
//  TIMEOUT_CYCLES  256 waitrequest cycles before abort (LSU_TIMEOUT_EN only)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-high reset
//  req_valid    in   1       core request valid
//  req_ready    out  1       LSU can accept (IDLE only)
//  req_write    in   1       1=store, 0=load
//  req_size     in   2       lsu_size_t: 0=BYTE, 1=HALF, 2=WORD (3 = error)
//  req_signed   in   1       sign-extend load result (LB/LH)
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data, low bits significant
//  resp_valid   out  1       one-cycle completion pulse
//  resp_rdata   out  32      extended load data; 0 for stores/errors
//  resp_err     out  1       qualifies resp_valid: misaligned, bad size, or timeout
//  address      out  ADDR_W  bus address, aligned to BE_W bytes
//  read, write  out  1       bus strobes, never both high
//  waitrequest  in   1       slave stall
//  writedata    out  DATA_W  lane-replicated store data
//  byteenable   out  BE_W    active lanes
//  readdata     in   DATA_W  valid in cycle where read=1 and waitrequest=0
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; read=write=0; address=0; byteenable=0; writedata=0.
//  FSM IDLE -> BUS -> RESP -> IDLE; IDLE -> RESP direct on error.
//  IDLE: on req_valid&&req_ready latch all req_* fields; goto BUS, or RESP with err if misaligned or size=3.
//   Misaligned: HALF with addr[0]=1, WORD with addr[1:0]!=0. No bus cycle issued.
//  BUS: read=!wr, write=wr; address={addr[ADDR_W-1:log2(BE_W)], 0}; lane k=addr[log2(BE_W)-1:0].
//   Outputs held stable while waitrequest=1. Exit when waitrequest=0; capture readdata that cycle.
//  RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in BUS and RESP.
//  Lanes, little-endian: BYTE be=1<<k; HALF be=2'b11<<k; WORD be=4'hF<<k.
//   writedata = req_wdata[size-bits] replicated across all DATA_W.
//  Load: extract size-bits from readdata at byte k; sign-extend if req_signed, else zero-extend.
//  Latency: accept at edge N; bus strobe during N+1; with no stall resp_valid during N+2.
//   Each waitrequest cycle adds one cycle. Error path: resp_valid during N+1.
//  Reset mid-transaction: strobes drop asynchronously, response discarded; abort accepted at reset.
//  Back-to-back: new request accepted in cycle after resp_valid (throughput 1 per 3 cycles min).
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: counter clears on BUS entry and counts waitrequest=1 cycles.
//   At TIMEOUT_CYCLES, strobes drop, go RESP with resp_err=1 and resp_rdata=0.
//  Not defined: no counter, BUS waits indefinitely; TIMEOUT_CYCLES ignored.
// STRUCTURE
//  Package mips_lsu_pkg: lsu_size_t enum (BYTE/HALF/WORD), lsu_state_t enum (IDLE/BUS/RESP),
//   and function lane_mask(size,k) for byteenable generation.
//  Sub-module mips_lsu_align (combinational): readdata+lane+size+signed -> 32-bit result.
//  Parent holds FSM, request latch, bus drive and optional timeout counter.
// TESTING
//  1 SB addr=0x1003 wdata=0xAB, DATA_W=32, no stall -> address=0x1000, be=4'b1000,
//    writedata=0xABABABAB, resp_valid during N+2, err=0.
//  2 LH signed addr=0x2002, readdata=0x80010000, 3 waitrequest cycles
//    -> strobes held stable for 4 cycles, resp_rdata=0xFFFF8001.
//  3 LBU addr=0x3005, DATA_W=64, readdata=0x0000_7F00_0000_0000 -> address=0x3000,
//    be=8'h20, resp_rdata=0x0000007F.
//  4 LW addr=0x4002 -> no read/write asserted; resp_valid during N+1 with err=1, rdata=0.
//  5 Assert reset during BUS stall of a SW -> write=0 immediately, req_ready=1, no resp_valid.
//  6 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck high -> read drops after 4 stall cycles,
//    resp_err=1; without macro read stays high.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared types and lane-mask helper for the MIPS load/store unit.
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Little-endian byteenable for an access of the given size starting at lane k.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] k);
    logic [7:0] m;
    case (size)
      BYTE:    m = 8'h01 << k;
      HALF:    m = 8'h03 << k;
      WORD:    m = 8'h0F << k;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Load-data aligner: selects the addressed bytes from the bus word and extends to 32 bits.
module mips_lsu_align
  import mips_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_readdata,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  output logic [31:0]       o_rdata_c
);

  logic [31:0] w_shifted;

  assign w_shifted = 32'(i_readdata >> {i_lane, 3'b000});

  always_comb begin
    o_rdata_c = w_shifted;
    case (i_size)
      BYTE:    o_rdata_c = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
      HALF:    o_rdata_c = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: o_rdata_c = w_shifted;
    endcase
  end

endmodule

// File: rtl/mips_lsu_bus.sv
// Load/store unit bridging the multicycle MIPS core to an Avalon-MM master port.
// Optional waitrequest timeout is enabled by defining LSU_TIMEOUT_EN.
module mips_lsu_bus
  import mips_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(BE_W);

  lsu_state_t        r_state, w_nxt_state;
  logic              r_req_ready, w_nxt_req_ready;
  logic              r_resp_valid, w_nxt_resp_valid;
  logic [31:0]       r_resp_rdata, w_nxt_resp_rdata;
  logic              r_resp_err, w_nxt_resp_err;
  logic [ADDR_W-1:0] r_address, w_nxt_address;
  logic              r_read, w_nxt_read;
  logic              r_write, w_nxt_write;
  logic [DATA_W-1:0] r_writedata, w_nxt_writedata;
  logic [BE_W-1:0]   r_byteenable, w_nxt_byteenable;

  logic              r_wr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [LANE_W-1:0] r_lane;

  logic              w_accept;
  logic              w_bad;
  logic              w_to_hit;
  logic [LANE_W-1:0] w_lane;
  logic [7:0]        w_mask8;
  logic [DATA_W-1:0] w_rep;
  logic [31:0]       w_load_data;

  assign w_accept = req_valid && r_req_ready && (r_state == IDLE);
  assign w_lane   = req_addr[LANE_W-1:0];
  assign w_mask8  = lane_mask(req_size, 3'(w_lane));
  assign w_bad    = (req_size == 2'd3)
                 || ((req_size == HALF) && req_addr[0])
                 || ((req_size == WORD) && (req_addr[1:0] != 2'b00));

  always_comb begin
    case (req_size)
      BYTE:    w_rep = {BE_W{req_wdata[7:0]}};
      HALF:    w_rep = {(DATA_W / 16){req_wdata[15:0]}};
      default: w_rep = {(DATA_W / 32){req_wdata}};
    endcase
  end

  mips_lsu_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_align (
    .i_readdata (readdata),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_signed   (r_signed),
    .o_rdata_c  (w_load_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Counts stalled bus cycles of the current transfer; the last one aborts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
    end else if ((r_state == BUS) && waitrequest) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_to_hit = waitrequest && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // Timeout disabled: a stalled transfer waits indefinitely.
  assign w_to_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Request latch for the load-return path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_lane   <= '0;
    end else if (w_accept) begin
      r_wr     <= req_write;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_lane   <= w_lane;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_address    <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_writedata  <= '0;
      r_byteenable <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_req_ready  <= w_nxt_req_ready;
      r_resp_valid <= w_nxt_resp_valid;
      r_resp_rdata <= w_nxt_resp_rdata;
      r_resp_err   <= w_nxt_resp_err;
      r_address    <= w_nxt_address;
      r_read       <= w_nxt_read;
      r_write      <= w_nxt_write;
      r_writedata  <= w_nxt_writedata;
      r_byteenable <= w_nxt_byteenable;
    end
  end

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_req_ready  = r_req_ready;
    w_nxt_resp_valid = 1'b0;
    w_nxt_resp_rdata = 32'd0;
    w_nxt_resp_err   = 1'b0;
    w_nxt_address    = r_address;
    w_nxt_read       = r_read;
    w_nxt_write      = r_write;
    w_nxt_writedata  = r_writedata;
    w_nxt_byteenable = r_byteenable;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nxt_req_ready = 1'b0;
          if (w_bad) begin
            w_nxt_state      = RESP;
            w_nxt_resp_valid = 1'b1;
            w_nxt_resp_err   = 1'b1;
          end else begin
            w_nxt_state      = BUS;
            w_nxt_read       = !req_write;
            w_nxt_write      = req_write;
            w_nxt_address    = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            w_nxt_byteenable = w_mask8[BE_W-1:0];
            w_nxt_writedata  = w_rep;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          w_nxt_state      = RESP;
          w_nxt_read       = 1'b0;
          w_nxt_write      = 1'b0;
          w_nxt_resp_valid = 1'b1;
          w_nxt_resp_rdata = r_wr ? 32'd0 : w_load_data;
        end else if (w_to_hit) begin
          w_nxt_state      = RESP;
          w_nxt_read       = 1'b0;
          w_nxt_write      = 1'b0;
          w_nxt_resp_valid = 1'b1;
          w_nxt_resp_err   = 1'b1;
        end
      end
      RESP: begin
        w_nxt_state     = IDLE;
        w_nxt_req_ready = 1'b1;
      end
      default: begin
        w_nxt_state     = IDLE;
        w_nxt_req_ready = 1'b1;
        w_nxt_read      = 1'b0;
        w_nxt_write     = 1'b0;
      end
    endcase
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;

endmodule

// File: tb/tb_mips_lsu_bus.sv
// Directed scoreboard bench for mips_lsu_bus: 32-bit and 64-bit bus instances.
// Timeout expectations follow LSU_TIMEOUT_EN.
module tb_mips_lsu_bus;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        valid_a, ready_a, rv_a, rerr_a, rd_a, wr_a, wait_a;
  logic [31:0] rdata_a, addr_a, wdata_a, bus_rdata_a;
  logic [3:0]  be_a;

  logic        valid_b, ready_b, rv_b, rerr_b, rd_b, wr_b, wait_b;
  logic [31:0] rdata_b, addr_b;
  logic [63:0] wdata_b, bus_rdata_b;
  logic [7:0]  be_b;

  int checks   = 0;
  int failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  mips_lsu_bus #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(valid_a), .req_ready(ready_a),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_a),
    .resp_rdata(rdata_a), .resp_err(rerr_a), .address(addr_a), .read(rd_a),
    .write(wr_a), .waitrequest(wait_a), .writedata(wdata_a),
    .byteenable(be_a), .readdata(bus_rdata_a)
  );

  mips_lsu_bus #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(4)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(valid_b), .req_ready(ready_b),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_b),
    .resp_rdata(rdata_b), .resp_err(rerr_b), .address(addr_b), .read(rd_b),
    .write(wr_b), .waitrequest(wait_b), .writedata(wdata_b),
    .byteenable(be_b), .readdata(bus_rdata_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
  endtask

  // Waits (bounded) for the response pulse, checks latency and scoreboard entry,
  // then confirms the pulse lasts one cycle and the LSU is ready again.
  task automatic collect(input bit sel_b, input int lat, input string tag);
    int   n;
    logic v;
    exp_t e;
    n = 0;
    v = sel_b ? rv_b : rv_a;
    while (!v && n < 20) begin
      tick();
      n++;
      v = sel_b ? rv_b : rv_a;
    end
    chk({tag, "_resp_valid"}, 64'(v), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_sb_nonempty"}, 64'(sel_b ? q_b.size() : q_a.size()), 64'd1);
    if (sel_b ? (q_b.size() != 0) : (q_a.size() != 0)) begin
      e = sel_b ? q_b.pop_front() : q_a.pop_front();
      chk({tag, "_rdata"}, 64'(sel_b ? rdata_b : rdata_a), 64'(e.rdata));
      chk({tag, "_err"}, 64'(sel_b ? rerr_b : rerr_a), 64'(e.err));
    end
    tick();
    chk({tag, "_pulse_end"}, 64'(sel_b ? rv_b : rv_a), 64'd0);
    chk({tag, "_ready"}, 64'(sel_b ? ready_b : ready_a), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    wait_a = 1'b0;  wait_b = 1'b0;
    bus_rdata_a = 32'd0; bus_rdata_b = 64'd0;
    drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    tick(); tick();

    chk("rst_ready", 64'(ready_a), 64'd1);
    chk("rst_resp", 64'({rv_a, rerr_a, rdata_a}), 64'd0);
    chk("rst_strobes", 64'({rd_a, wr_a, rd_b, wr_b}), 64'd0);
    chk("rst_bus", 64'({addr_a, be_a}), 64'd0);
    chk("rst_wdata", 64'(wdata_a), 64'd0);
    reset = 1'b0;
    tick();

    // SB, no stall
    drive(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB);
    valid_a = 1'b1;
    q_a.push_back('{32'd0, 1'b0});
    tick();
    valid_a = 1'b0;
    chk("sb_strobes", 64'({rd_a, wr_a}), 64'b01);
    chk("sb_addr", 64'(addr_a), 64'h1000);
    chk("sb_be", 64'(be_a), 64'b1000);
    chk("sb_wdata", 64'(wdata_a), 64'hABAB_ABAB);
    chk("sb_busy", 64'(ready_a), 64'd0);
    collect(1'b0, 1, "sb");

    // LH signed, three stall cycles, issued back-to-back
    wait_a = 1'b1;
    bus_rdata_a = 32'h8001_0000;
    drive(1'b0, 2'd1, 1'b1, 32'h2002, 32'd0);
    valid_a = 1'b1;
    q_a.push_back('{32'hFFFF_8001, 1'b0});
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lh_hold", 64'({rd_a, wr_a, addr_a, be_a}), {26'd0, 1'b1, 1'b0, 32'h2000, 4'b1100});
      tick();
    end
    chk("lh_hold4", 64'({rd_a, wr_a, addr_a, be_a}), {26'd0, 1'b1, 1'b0, 32'h2000, 4'b1100});
    wait_a = 1'b0;
    collect(1'b0, 1, "lh");

    // LB signed, negative byte on lane 1
    bus_rdata_a = 32'h0000_F000;
    drive(1'b0, 2'd0, 1'b1, 32'h0000_0011, 32'd0);
    valid_a = 1'b1;
    q_a.push_back('{32'hFFFF_FFF0, 1'b0});
    tick();
    valid_a = 1'b0;
    chk("lb_be", 64'(be_a), 64'b0010);
    collect(1'b0, 1, "lb");

    // SH on upper half
    drive(1'b1, 2'd1, 1'b0, 32'h6002, 32'h1234_BEEF);
    valid_a = 1'b1;
    q_a.push_back('{32'd0, 1'b0});
    tick();
    valid_a = 1'b0;
    chk("sh_wdata", 64'(wdata_a), 64'hBEEF_BEEF);
    chk("sh_be", 64'(be_a), 64'b1100);
    collect(1'b0, 1, "sh");

    // Misaligned LW: no bus cycle, error one cycle after accept
    drive(1'b0, 2'd2, 1'b0, 32'h4002, 32'd0);
    valid_a = 1'b1;
    q_a.push_back('{32'd0, 1'b1});
    tick();
    valid_a = 1'b0;
    chk("mis_strobes", 64'({rd_a, wr_a}), 64'd0);
    collect(1'b0, 0, "mis");

    // Illegal size code
    drive(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0);
    valid_a = 1'b1;
    q_a.push_back('{32'd0, 1'b1});
    tick();
    valid_a = 1'b0;
    chk("sz3_strobes", 64'({rd_a, wr_a}), 64'd0);
    collect(1'b0, 0, "sz3");

    // 64-bit bus: LBU on lane 5
    bus_rdata_b = 64'h0000_7F00_0000_0000;
    drive(1'b0, 2'd0, 1'b0, 32'h3005, 32'd0);
    valid_b = 1'b1;
    q_b.push_back('{32'h0000_007F, 1'b0});
    tick();
    valid_b = 1'b0;
    chk("lbu64_addr", 64'(addr_b), 64'h3000);
    chk("lbu64_be", 64'(be_b), 64'h20);
    chk("lbu64_read", 64'({rd_b, wr_b}), 64'b10);
    collect(1'b1, 1, "lbu64");

    // 64-bit bus: SW into upper word
    drive(1'b1, 2'd2, 1'b0, 32'h3004, 32'hCAFE_F00D);
    valid_b = 1'b1;
    q_b.push_back('{32'd0, 1'b0});
    tick();
    valid_b = 1'b0;
    chk("sw64_wdata", wdata_b, 64'hCAFE_F00D_CAFE_F00D);
    chk("sw64_be", 64'(be_b), 64'hF0);
    collect(1'b1, 1, "sw64");

    // Reset during a stalled SW: strobe drops at once, response discarded
    wait_a = 1'b1;
    drive(1'b1, 2'd2, 1'b0, 32'h5000, 32'h1111_2222);
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    chk("rstmid_write", 64'(wr_a), 64'd1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_drop", 64'({rd_a, wr_a}), 64'd0);
    chk("rstmid_ready", 64'(ready_a), 64'd1);
    #1;
    reset = 1'b0;
    wait_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstmid_no_resp", 64'(rv_a), 64'd0);
    end

    // Stuck waitrequest on a LW
    wait_a = 1'b1;
    drive(1'b0, 2'd2, 1'b0, 32'h7000, 32'd0);
    valid_a = 1'b1;
`ifdef LSU_TIMEOUT_EN
    q_a.push_back('{32'd0, 1'b1});
`endif
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_read_hold", 64'(rd_a), 64'd1);
      tick();
    end
`ifdef LSU_TIMEOUT_EN
    chk("to_read_drop", 64'(rd_a), 64'd0);
    collect(1'b0, 0, "to");
`else
    for (int i = 0; i < 6; i++) begin
      chk("to_read_stays", 64'(rd_a), 64'd1);
      chk("to_no_resp", 64'(rv_a), 64'd0);
      tick();
    end
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
`endif
    wait_a = 1'b0;

    chk("sb_a_drained", 64'(q_a.size()), 64'd0);
    chk("sb_b_drained", 64'(q_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
